// File: rtl/axis_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_rr_arbiter
// Description : N-input AXI4-Stream packet arbiter with round-robin priority,
//               packet-atomic grants and a registered, source-tagged output.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        s_tvalid,
  input  logic [NUM_IN-1:0]        s_tlast,
  input  logic [NUM_IN*DATA_W-1:0] s_tdata,
  output logic [NUM_IN-1:0]        s_tready,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [ID_W-1:0]          m_tid,
  input  logic                     m_tready,
  output logic                     busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_grant;
  logic [ID_W-1:0]     w_grant_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     w_rr_ptr_nxt;

  logic                r_m_tvalid;
  logic                r_m_tlast;
  logic [DATA_W-1:0]   r_m_tdata;
  logic [ID_W-1:0]     r_m_tid;

  logic [2*NUM_IN-1:0] w_req_dbl;
  logic [ID_W-1:0]     w_sel;
  logic                w_found;
  logic                w_out_free;
  logic [NUM_IN-1:0]   w_ready;
  logic                w_hs;
  logic                w_hs_last;
  logic [DATA_W-1:0]   w_gnt_data;

  // Doubling the request vector lets the search window [rr_ptr, rr_ptr+NUM_IN)
  // cover the wrap without a modulo on a variable index.
  assign w_req_dbl = {s_tvalid, s_tvalid};

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int j = 2*NUM_IN-1; j >= 0; j--) begin
      if (w_req_dbl[j] && (j >= int'(r_rr_ptr)) && (j < int'(r_rr_ptr) + NUM_IN)) begin
        w_found = 1'b1;
        w_sel   = ID_W'(j % NUM_IN);
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant == ID_W'(i)) begin
        w_gnt_data = s_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_out_free = !r_m_tvalid || m_tready;
  assign w_ready    = (r_state == XFER) ? ({{(NUM_IN-1){1'b0}}, w_out_free} << r_grant) : '0;
  assign w_hs       = |(s_tvalid & w_ready);
  assign w_hs_last  = |(s_tvalid & s_tlast & w_ready);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_sel;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_hs_last) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = (r_grant == ID_W'(NUM_IN-1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      // A load wins over a drain so accept-and-refill keeps one beat per cycle.
      if (w_hs) begin
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= w_hs_last;
        r_m_tdata  <= w_gnt_data;
        r_m_tid    <= r_grant;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign s_tready = w_ready;
  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign m_tdata  = r_m_tdata;
  assign m_tid    = r_m_tid;
  assign busy     = (r_state == XFER);

endmodule
`default_nettype wire
